lsu_dbus_ctrl: RTL and testbench

- Load/store unit directly downstream of the ALU: takes alu_result as effective address and rs2_data as store data, runs one data-bus transaction per load/store.
- Stalls the single-cycle core until the access completes.
- Performs byte-lane steering, write-strobe generation and load sign/zero extension.
- Detects misaligned accesses.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_dbus_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_dbus_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state encoding and strobe constants for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // funct3[1:0] encodes the access size; byte accesses can never be misaligned
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic half_bad, word_bad;
    half_bad = (f3[1:0] == 2'b01) && lo[0];
    word_bad = f3[1] && (lo != 2'b00);
    return half_bad || word_bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, write strobes, load extension and misalign detect
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  assign misaligned = is_misaligned(funct3, addr_lo);

  always_comb begin
    wstrb = STRB_W;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = STRB_B << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = STRB_H << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0; LW is aligned so the shift is zero
  always_comb begin
    shifted = rdata >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_ext = {24'd0, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// rtl/lsu_dbus_ctrl.sv - load/store data-bus FSM with core stall; LSU_TIMEOUT_EN adds a bus timeout
module lsu_dbus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] load_q;
  logic        err_q;

  logic        access;
  logic        mis_raw;
  logic        start;
  logic        timeout;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [31:0] load_ext;

  lsu_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .ld_funct3  (f3_q),
    .ld_addr_lo (addr_q[1:0]),
    .rdata      (dbus_rdata),
    .wstrb      (wstrb_c),
    .wdata      (wdata_c),
    .misaligned (mis_raw),
    .load_ext   (load_ext)
  );

  assign access     = mem_read | mem_write;
  assign misaligned = access & mis_raw;
  assign start      = (state == IDLE) & access & ~mis_raw;
  assign stall      = start | (state == REQ) | (state == WAIT);
  assign done       = (state == DONE);
  assign dbus_req   = (state == REQ);
  assign dbus_we    = we_q;
  assign dbus_addr  = {addr_q[31:2], 2'b00};
  assign dbus_wstrb = wstrb_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = load_q;
  assign bus_err    = err_q;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign timeout = ((state == REQ) || (state == WAIT)) &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !((state == REQ) || (state == WAIT))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata_c;
            wstrb_q <= wstrb_c;
            f3_q    <= funct3;
            we_q    <= mem_write;
            state   <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            err_q  <= 1'b1;
            load_q <= '0;
            state  <= DONE;
          end else if (dbus_gnt) begin
            if (we_q) begin
              state <= DONE;
            end else if (dbus_rvalid) begin
              load_q <= load_ext;
              state  <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (timeout) begin
            err_q  <= 1'b1;
            load_q <= '0;
            state  <= DONE;
          end else if (dbus_rvalid) begin
            load_q <= load_ext;
            state  <= DONE;
          end
        end
        DONE: begin
          // The core advances on this edge, so the same access is not re-issued
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// tb/tb_lsu_dbus_ctrl.sv - self-checking bench: vector table, random accesses vs reference model
module tb_lsu_dbus_ctrl;

  logic        clk, rst, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, done, misaligned, bus_err, dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  int total;
  int passed;
  logic [31:0] prev_load;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] exp_load;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    int          exp_stall;
  } vec_t;

  vec_t vecs[11];

  lsu_dbus_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .load_data   (load_data),
    .stall       (stall),
    .done        (done),
    .misaligned  (misaligned),
    .bus_err     (bus_err),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_wstrb  (dbus_wstrb),
    .dbus_wdata  (dbus_wdata),
    .dbus_gnt    (dbus_gnt),
    .dbus_rvalid (dbus_rvalid),
    .dbus_rdata  (dbus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int gd, input int rv, input logic [31:0] el,
                              input logic [3:0] ews, input logic [31:0] ewd,
                              input logic emis, input int est);
    vec_t v;
    v.we = we; v.re = re; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.gnt_dly = gd; v.rv_dly = rv; v.exp_load = el; v.exp_wstrb = ews;
    v.exp_wdata = ewd; v.exp_mis = emis; v.exp_stall = est;
    return v;
  endfunction

  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> ((a % 4) * 8);
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Expected results for an access, derived from the access rules with plain arithmetic
  function automatic vec_t model(input vec_t v, input logic [31:0] last_load);
    vec_t r;
    int sz;
    r = v;
    sz = access_size(v.f3);
    r.exp_mis = ((v.addr % sz) != 0);
    r.exp_wstrb = 4'(((1 << sz) - 1) << (v.addr % 4));
    if (sz == 1) r.exp_wdata = (v.sdata & 32'hFF) * 32'h01010101;
    else if (sz == 2) r.exp_wdata = (v.sdata & 32'hFFFF) * 32'h00010001;
    else r.exp_wdata = v.sdata;
    r.exp_load = last_load;
    if (r.exp_mis) begin
      r.exp_stall = 0;
    end else begin
      r.exp_stall = 1 + (v.gnt_dly + 1) + ((v.we) ? 0 : v.rv_dly);
      if (!v.we) r.exp_load = model_load(v.f3, v.addr, v.rdata);
    end
    return r;
  endfunction

  // Entered and left at posedge+1; plays the bus slave with the vector's delays
  task automatic run_vec(input vec_t v, input string tag);
    int stall_n, done_n, req_n, gnt_c;
    logic req_seen, err_seen, mis_seen, finished;
    logic [31:0] ld, a_o, wd_o;
    logic [3:0] ws_o;
    logic we_o;
    stall_n = 0; done_n = 0; req_n = 0; gnt_c = -1;
    req_seen = 0; err_seen = 0; mis_seen = 0; finished = 0;
    ld = '0; a_o = '0; wd_o = '0; ws_o = '0; we_o = 0;
    mem_read = v.re; mem_write = v.we; funct3 = v.f3; addr = v.addr;
    store_data = v.sdata; dbus_rdata = v.rdata;
    for (int c = 0; c < 40 && !finished; c++) begin
      dbus_gnt = 0;
      dbus_rvalid = 0;
      if (dbus_req) begin
        if (!req_seen) begin
          we_o = dbus_we; a_o = dbus_addr; ws_o = dbus_wstrb; wd_o = dbus_wdata;
        end
        req_seen = 1;
        if (req_n == v.gnt_dly) begin
          dbus_gnt = 1;
          gnt_c = c;
          if (v.re && !v.we && v.rv_dly == 0) dbus_rvalid = 1;
        end
        req_n++;
      end else if (gnt_c >= 0 && v.re && !v.we && v.rv_dly > 0 && c == gnt_c + v.rv_dly) begin
        dbus_rvalid = 1;
      end
      @(negedge clk);
      if (stall) stall_n++;
      if (misaligned) mis_seen = 1;
      if (bus_err) err_seen = 1;
      if (done) begin
        done_n++;
        finished = 1;
      end
      if (v.exp_mis && c == 3) finished = 1;
      ld = load_data;
      @(posedge clk); #1;
    end
    mem_read = 0; mem_write = 0; dbus_gnt = 0; dbus_rvalid = 0;
    @(negedge clk);
    if (done) done_n++;
    if (stall) stall_n++;
    @(posedge clk); #1;
    check({tag, " stall_cycles"}, stall_n, v.exp_stall);
    check({tag, " done_pulses"}, done_n, v.exp_mis ? 0 : 1);
    check({tag, " misaligned"}, 32'(mis_seen), 32'(v.exp_mis));
    check({tag, " load_data"}, ld, v.exp_load);
    check({tag, " bus_err"}, 32'(err_seen), 0);
    check({tag, " req_seen"}, 32'(req_seen), v.exp_mis ? 0 : 1);
    if (!v.exp_mis) begin
      check({tag, " dbus_we"}, 32'(we_o), 32'(v.we));
      check({tag, " dbus_addr"}, a_o, v.addr & 32'hFFFFFFFC);
      if (v.we) begin
        check({tag, " dbus_wstrb"}, 32'(ws_o), 32'(v.exp_wstrb));
        check({tag, " dbus_wdata"}, wd_o, v.exp_wdata);
      end
    end
  endtask

  initial begin
    vec_t rv;
    int op, done_at, stall_hi, done_n;
    logic [2:0] st_f3[3];
    logic [2:0] ld_f3[5];
    logic err_at_done, req_at_done;
    logic [31:0] ld_at_done;
    st_f3 = '{3'b000, 3'b001, 3'b010};
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    total = 0; passed = 0;

    vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0, 4'hF, 32'hDEADBEEF, 0, 2);
    vecs[1]  = mk(0, 1, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 3, 32'hFFFFFF80, 0, 0, 0, 5);
    vecs[2]  = mk(0, 1, 3'b101, 32'h202, 0, 32'h80FF1234, 0, 0, 32'h000080FF, 0, 0, 0, 2);
    vecs[3]  = mk(1, 0, 3'b001, 32'h206, 32'h0000ABCD, 0, 0, 0, 32'h000080FF, 4'hC, 32'hABCDABCD, 0, 2);
    vecs[4]  = mk(0, 1, 3'b010, 32'h101, 0, 32'h11111111, 0, 0, 32'h000080FF, 0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 3'b000, 32'h101, 32'h00000012, 0, 0, 0, 32'h000080FF, 4'h2, 32'h12121212, 0, 2);
    vecs[6]  = mk(0, 1, 3'b001, 32'h102, 0, 32'h7FFF0000, 0, 1, 32'h00007FFF, 0, 0, 0, 3);
    vecs[7]  = mk(0, 1, 3'b100, 32'h001, 0, 32'h0000AB00, 1, 0, 32'h000000AB, 0, 0, 0, 3);
    vecs[8]  = mk(0, 1, 3'b010, 32'h204, 0, 32'h12345678, 2, 2, 32'h12345678, 0, 0, 0, 6);
    vecs[9]  = mk(1, 0, 3'b001, 32'h20B, 32'h5555AAAA, 0, 0, 0, 32'h12345678, 0, 0, 1, 0);
    vecs[10] = mk(1, 1, 3'b010, 32'h208, 32'hCAFEBABE, 32'h0BADF00D, 3, 0, 32'h12345678, 4'hF, 32'hCAFEBABE, 0, 5);

    rst = 1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dbus_req", 32'(dbus_req), 0);
    check("reset done", 32'(done), 0);
    check("reset bus_err", 32'(bus_err), 0);
    check("reset load_data", load_data, 0);
    check("reset stall", 32'(stall), 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data; the late rvalid must be ignored
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    dbus_gnt = dbus_req;
    @(posedge clk); #1;
    dbus_gnt = 0; rst = 1; mem_read = 0;
    @(negedge clk);
    check("wait stall", 32'(stall), 1);
    @(posedge clk); #1;
    rst = 0; dbus_rvalid = 1; dbus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_mid stall", 32'(stall), 0);
    check("rst_mid done", 32'(done), 0);
    check("rst_mid dbus_req", 32'(dbus_req), 0);
    check("rst_mid load_data", load_data, 0);
    @(posedge clk); #1;
    dbus_rvalid = 0;
    @(negedge clk);
    check("rst_mid stray done", 32'(done), 0);
    check("rst_mid stray load", load_data, 0);
    @(posedge clk); #1;

    prev_load = 32'h0;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 2);
      rv.re = (op != 1);
      rv.we = (op != 0);
      rv.f3 = rv.we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      rv.addr = $urandom;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.gnt_dly = $urandom_range(0, 3);
      rv.rv_dly = $urandom_range(0, 3);
      rv = model(rv, prev_load);
      run_vec(rv, $sformatf("rnd%0d", i));
      prev_load = rv.exp_load;
    end

    // Load that is never granted
    mem_read = 1; funct3 = 3'b010; addr = 32'h400;
`ifdef LSU_TIMEOUT_EN
    done_at = -1; err_at_done = 0; ld_at_done = 32'hFFFFFFFF; req_at_done = 1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c; err_at_done = bus_err; ld_at_done = load_data; req_at_done = dbus_req;
      end
      @(posedge clk); #1;
    end
    mem_read = 0;
    check("timeout done cycle", done_at, 9);
    check("timeout bus_err", 32'(err_at_done), 1);
    check("timeout load_data", ld_at_done, 0);
    check("timeout dbus_req", 32'(req_at_done), 0);
    dbus_rvalid = 1;
    @(negedge clk);
    check("timeout stray done", 32'(done), 0);
    check("timeout stray bus_err", 32'(bus_err), 0);
    @(posedge clk); #1;
    dbus_rvalid = 0;
`else
    stall_hi = 0; done_n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall) stall_hi++;
      if (done) done_n++;
      @(posedge clk); #1;
    end
    check("hang stall cycles", stall_hi, 100);
    check("hang done pulses", done_n, 0);
    check("hang bus_err", 32'(bus_err), 0);
    rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
